// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch. Owns the PC, issues single-outstanding word reads on the
//   instruction bus, buffers returned words and presents them to decode in program order.
// Latency: gnt in cycle N, rvalid in N+1, dec_valid in N+2; 1 instr/cycle sustained on a zero-wait bus.
// Backpressure: dec_ready low holds the head entry stable; issue stops once buffered + in-flight
//   words would exceed BUF_DEPTH (a pop in the same cycle frees a slot).
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- a misaligned PC produces one faulting NOP
//   entry and halts fetch until the next redirect; otherwise PC bits [1:0] are ignored.
// Ports: clk, rst (async, active-high)
//        next_pc_en/next_pc/bubble_fetch            from pipeline control
//        ibus_req/ibus_addr -> ibus_gnt/ibus_rvalid/ibus_rdata   instruction bus
//        dec_valid/dec_inst/dec_pc/dec_fault -> dec_ready        decode
module fetch_stage #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        next_pc_en,
  input  logic [31:0] next_pc,
  input  logic        bubble_fetch,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic        dec_fault
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(BUF_DEPTH);
  localparam logic [31:0]      NOP       = 32'h0000_0013;

  logic [31:0]      pc_q, pc_d;
  logic             out_q, out_d;        // one bus read in flight
  logic             drop_q, drop_d;      // in-flight read belongs to a flushed path
  logic [31:0]      req_addr_q, req_addr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      inst_q [BUF_DEPTH];
  logic [31:0]      inst_d [BUF_DEPTH];
  logic [31:0]      epc_q  [BUF_DEPTH];
  logic [31:0]      epc_d  [BUF_DEPTH];
`ifdef FETCH_MISALIGN_TRAP_EN
  logic             fault_q [BUF_DEPTH];
  logic             fault_d [BUF_DEPTH];
  logic             halt_q, halt_d;
  logic             fault_push;
  logic             push_fault;
`endif

  logic             pop, rsp, push_bus, push, gnt_take, space, issue_ok;
  logic [OCC_W-1:0] occ;
  logic [31:0]      push_inst, push_pc;

  assign ibus_addr = {pc_q[31:2], 2'b00};
  assign dec_valid = (count_q != '0) & ~bubble_fetch;
  assign dec_inst  = inst_q[rd_ptr_q];
  assign dec_pc    = epc_q[rd_ptr_q];
`ifdef FETCH_MISALIGN_TRAP_EN
  assign dec_fault = fault_q[rd_ptr_q];
`else
  assign dec_fault = 1'b0;
`endif

  always_comb begin
    // A redirect flushes the buffer, so a coincident pop is void.
    pop      = dec_valid & dec_ready & ~next_pc_en;
    // rvalid only means something while our request is in flight; stale ones after reset are ignored.
    rsp      = ibus_rvalid & out_q;
    push_bus = rsp & ~drop_q & ~next_pc_en;
    // Buffered + in-flight words, crediting this cycle's pop so depth 2 still streams 1/cycle.
    occ      = OCC_W'(count_q) + OCC_W'(out_q) - OCC_W'(pop);
    space    = occ < DEPTH_OCC;
    issue_ok = (~out_q | rsp) & space & ~next_pc_en;
`ifdef FETCH_MISALIGN_TRAP_EN
    issue_ok   = issue_ok & (pc_q[1:0] == 2'b00);
    // Wait for the bus to go quiet so the fault entry lands in program order.
    fault_push = (pc_q[1:0] != 2'b00) & ~halt_q & ~out_q & space & ~next_pc_en;
`endif
  end

  assign ibus_req = issue_ok & ~rst;
  assign gnt_take = ibus_req & ibus_gnt;

  always_comb begin
    pc_d       = pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    req_addr_d = req_addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inst_d     = inst_q;
    epc_d      = epc_q;
    push       = push_bus;
    push_inst  = ibus_rdata;
    push_pc    = req_addr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d    = fault_q;
    halt_d     = halt_q;
    push_fault = 1'b0;
    if (fault_push) begin
      push       = 1'b1;
      push_inst  = NOP;
      push_pc    = pc_q;
      push_fault = 1'b1;
      halt_d     = 1'b1;
    end
`endif
    if (rsp) begin
      out_d  = 1'b0;
      drop_d = 1'b0;
    end
    if (gnt_take) begin
      out_d      = 1'b1;
      req_addr_d = ibus_addr;
      pc_d       = pc_q + 32'd4;
    end
    if (push) begin
      inst_d[wr_ptr_q] = push_inst;
      epc_d[wr_ptr_q]  = push_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_d[wr_ptr_q] = push_fault;
`endif
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (next_pc_en) begin
      pc_d     = next_pc;
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
      // Keep out_q set so no new request goes out before the orphaned response returns.
      if (out_q & ~ibus_rvalid) drop_d = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_d = 1'b0;
`endif
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_ADDR;
      out_q      <= 1'b0;
      drop_q     <= 1'b0;
      req_addr_q <= RESET_ADDR;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        inst_q[i] <= NOP;
        epc_q[i]  <= RESET_ADDR;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_q[i] <= 1'b0;
`endif
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_q <= 1'b0;
`endif
    end else begin
      pc_q       <= pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      req_addr_q <= req_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inst_q     <= inst_d;
      epc_q      <= epc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q <= fault_d;
      halt_q  <= halt_d;
`endif
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam int          DEPTH      = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        next_pc_en = 1'b0;
  logic [31:0] next_pc = '0;
  logic        bubble_fetch = 1'b0;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_gnt = 1'b0;
  logic        ibus_rvalid = 1'b0;
  logic [31:0] ibus_rdata = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_fault;

  fetch_stage #(.RESET_ADDR(RESET_ADDR), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .next_pc_en(next_pc_en), .next_pc(next_pc),
    .bubble_fetch(bubble_fetch), .ibus_req(ibus_req), .ibus_addr(ibus_addr),
    .ibus_gnt(ibus_gnt), .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst),
    .dec_pc(dec_pc), .dec_fault(dec_fault)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  int          n_vec = 0;
  int          n_err = 0;
  ent_t        q[$];            // words that decode should see, in order
  logic [31:0] deliv[$];        // dec_pc values actually handed to decode
  logic [31:0] exp_fetch_pc;    // architectural next fetch address
  bit          model_on = 1'b1;
  int          gnt_pct = 100;
  int          lat_min = 1, lat_max = 1;
  // responder state for the single bus transaction
  bit          pend = 1'b0, doom = 1'b0, stale = 1'b0;
  int          lat_left = 0;
  logic [31:0] pend_addr, pend_exp;
  logic [31:0] last_gnt = 32'hFFFF_FFFF;
  bit          prev_stalled = 1'b0;
  logic        s_req, s_valid, s_fault;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'h0000_0013 + a;
  endfunction

  function automatic logic [31:0] deliv_at(input int k);
    return (deliv.size() > k) ? deliv[k] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    next_pc_en = 1'b0; next_pc = '0; bubble_fetch = 1'b0; dec_ready = 1'b0;
    ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0;
    q.delete();
    exp_fetch_pc = RESET_ADDR;
    prev_stalled = 1'b0;
    if (pend) stale = 1'b1;
    #2;
    check("rst_ibus_req", ibus_req, 0);
    check("rst_ibus_addr", ibus_addr, RESET_ADDR);
    check("rst_dec_valid", dec_valid, 0);
    check("rst_dec_inst", dec_inst, 32'h0000_0013);
    check("rst_dec_pc", dec_pc, RESET_ADDR);
    check("rst_dec_fault", dec_fault, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, sample/check outputs, then advance the reference model.
  task automatic step(input bit redir, input logic [31:0] tgt, input bit rdy, input bit bub);
    bit   rv, exp_v, pop;
    logic [31:0] al;
    rv = 1'b0;
    if (pend) begin
      if (lat_left > 0) lat_left--;
      if (lat_left == 0) rv = 1'b1;
    end
    next_pc_en   = redir;
    next_pc      = tgt;
    dec_ready    = rdy;
    bubble_fetch = bub;
    ibus_rvalid  = rv;
    ibus_rdata   = rv ? inst_of(pend_addr) : $urandom;
    ibus_gnt     = ($urandom_range(99) < gnt_pct) && (!pend || rv);
    #2;
    s_req = ibus_req; s_addr = ibus_addr; s_valid = dec_valid;
    s_pc = dec_pc; s_inst = dec_inst; s_fault = dec_fault;
    exp_v = (q.size() != 0) && !bub;
    if (model_on) begin
      check("dec_valid", dec_valid, exp_v);
      if (exp_v) begin
        check("dec_pc", dec_pc, q[0].pc);
        check("dec_inst", dec_inst, q[0].inst);
        check("dec_fault", dec_fault, 0);
      end
      if (ibus_req) check("ibus_addr", ibus_addr, {exp_fetch_pc[31:2], 2'b00});
    end
    check("redirect_no_req", redir & ibus_req, 0);
    check("one_outstanding", ibus_req & pend & !rv & !stale, 0);
    if (prev_stalled && !redir) check("req_hold", ibus_req, 1);
    if (dec_valid && rdy && !redir) deliv.push_back(dec_pc);
    // model update at the clock edge
    pop = exp_v && rdy && !redir;
    if (pop) void'(q.pop_front());
    if (rv) begin
      if (!doom && !stale && !redir && model_on) q.push_back('{pc: pend_exp, inst: inst_of(pend_exp)});
      pend = 1'b0;
    end
    if (redir) begin
      q.delete();
      exp_fetch_pc = tgt;
      if (pend) doom = 1'b1;
    end else if (ibus_req && ibus_gnt) begin
      al        = {exp_fetch_pc[31:2], 2'b00};
      pend      = 1'b1; doom = 1'b0; stale = 1'b0;
      lat_left  = $urandom_range(lat_max, lat_min);
      pend_addr = ibus_addr;
      pend_exp  = al;
      last_gnt  = ibus_addr;
      exp_fetch_pc = exp_fetch_pc + 32'd4;
    end
    prev_stalled = ibus_req && !ibus_gnt;
    if (model_on) check("buf_bound", q.size() <= DEPTH, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int nf;
    logic [31:0] r, tgt;
    @(posedge clk); #1;
    apply_reset();

    // zero-wait bus: 0x0, 0x4, 0x8 delivered on consecutive cycles
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 0);
      check("stream_valid", s_valid, 1);
      check("stream_pc", s_pc, 32'(4 * k));
    end

    // decode stall: two words buffered, bus idle, head stable
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0);
    check("stall_req", s_req, 0);
    check("stall_pc", s_pc, 32'h0000_000C);
    check("stall_inst", s_inst, 32'h0000_001F);

    // redirect while the read of 0x8 is in flight
    apply_reset();
    lat_min = 3; lat_max = 3; last_gnt = 32'hFFFF_FFFF;
    for (int i = 0; i < 30 && last_gnt != 32'h8; i++) step(0, 0, 1, 0);
    check("redir_gnt8", last_gnt, 32'h8);
    lat_min = 1; lat_max = 1;
    deliv.delete();
    step(1, 32'h100, 1, 0);
    for (int k = 0; k < 12; k++) step(0, 0, 1, 0);
    check("redir_first_pc", deliv_at(0), 32'h100);
    check("redir_second_pc", deliv_at(1), 32'h104);

    // bubble with a full buffer
    apply_reset();
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1);
      check("bubble_valid", s_valid, 0);
    end
    deliv.delete();
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0);
    check("bubble_first_pc", deliv_at(0), 32'h0);
    check("bubble_second_pc", deliv_at(1), 32'h4);

    // reset while a response is pending
    apply_reset();
    lat_min = 3; lat_max = 3;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    apply_reset();
    deliv.delete();
    step(0, 0, 1, 0);
    check("rst_first_req", s_req, 1);
    check("rst_first_addr", s_addr, RESET_ADDR);
    for (int k = 0; k < 15; k++) step(0, 0, 1, 0);
    check("rst_first_pc", deliv_at(0), RESET_ADDR);
    check("rst_second_pc", deliv_at(1), RESET_ADDR + 32'd4);

    // randomized traffic
    apply_reset();
    gnt_pct = 70; lat_min = 1; lat_max = 3;
    for (int c = 0; c < 1500; c++) begin
      bit rd;
      rd = ($urandom_range(19) == 0);
      r  = $urandom;
      tgt = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : (r & 32'h0000_FFFC);
      step(rd, tgt, $urandom_range(9) < 7, $urandom_range(4) == 0);
    end

    apply_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
`ifdef FETCH_MISALIGN_TRAP_EN
    model_on = 1'b0;
    step(1, 32'h102, 1, 0);
    nf = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, 0);
      check("trap_no_req", s_req, 0);
      if (s_valid) begin
        nf++;
        check("trap_fault", s_fault, 1);
        check("trap_pc", s_pc, 32'h102);
        check("trap_inst", s_inst, 32'h0000_0013);
      end
    end
    check("trap_entries", nf, 1);
    step(1, 32'h200, 1, 0);
    step(0, 0, 1, 0);
    check("trap_resume_req", s_req, 1);
    check("trap_resume_addr", s_addr, 32'h200);
`else
    nf = 0;
    deliv.delete();
    step(1, 32'h102, 1, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, 0);
      if (s_valid) nf++;
    end
    check("align_first_pc", deliv_at(0), 32'h100);
    check("align_second_pc", deliv_at(1), 32'h104);
    check("align_delivered", nf > 2, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
